knn_list_ctrl: RTL and testbench
================================

Name: knn_list_ctrl

Overview:
Sequencer for the K-entry sorted neighbour list, a chain of list_element stages. Per test point it clears the list and streams N (distance, label) candidates into it, one per cycle. It then reads the K sorted neighbours back out over a valid/ready stream, nearest first. It sits between the distance unit, which produces candidates, and the label-vote logic, which consumes neighbours.

Parameters:
DATA_W, 32, distance width
LABEL_W, 8, label width
K, 10, list depth (number of neighbours), K >= 2
N_W, 16, width of training-point count
SEL_W, $clog2(K), readout index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin classification of one test point; sampled only in IDLE
n_points  in  N_W  number of candidates to process; latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of readout
cand_valid  in  1  candidate available
cand_ready  out  1  controller accepts candidate
cand_dist  in  DATA_W  candidate distance
cand_label  in  LABEL_W  candidate label
list_clear  out  1  one-cycle clear of all list entries (dist = all-ones, label = 0)
list_start  out  1  list enable; high in INSERT and SETTLE
list_valid  out  1  one-cycle insert strobe
list_dist  out  DATA_W  registered candidate distance to list
list_label  out  LABEL_W  registered candidate label to list
list_sel  out  SEL_W  readout select into list
list_rd_dist  in  DATA_W  distance of selected entry (combinational from list)
list_rd_label  in  LABEL_W  label of selected entry
nb_valid  out  1  neighbour output valid
nb_ready  in  1  neighbour consumer ready
nb_dist  out  DATA_W  neighbour distance (= list_rd_dist)
nb_label  out  LABEL_W  neighbour label (= list_rd_label)
nb_idx  out  SEL_W  neighbour rank, 0 = nearest

Behaviour:
- Reset (rst_n low, asynchronous) forces state IDLE and sets every output low/zero, including busy, done, cand_ready, list_*, nb_* and counters. Reset asserted mid-operation aborts immediately; there is no partial readout.
- FSM states: IDLE, CLEAR, INSERT, SETTLE, READ, DONE.
- IDLE:
  - start=1 latches n_points into cnt_max and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR (1 cycle):
  - list_clear=1; insert counter cleared.
  - Next state is INSERT if cnt_max>0, else SETTLE.
- INSERT:
  - cand_ready=1 for the whole state.
  - Handshake is cand_valid & cand_ready.
  - On handshake: list_dist/list_label are registered, list_valid pulses in the following cycle, and the counter increments.
  - Full rate: one candidate per cycle.
  - cand_valid low inserts bubbles; list_valid stays low and the count does not advance.
  - Handshake making count == cnt_max: cand_ready drops the next cycle and the state goes to SETTLE.
- SETTLE (1 cycle):
  - list_valid for the last candidate is active here (list_start still high).
  - list_sel=0; next state READ.
- READ:
  - nb_valid=1; list_sel=nb_idx=read index; nb_dist/nb_label pass through from the list.
  - Outputs are stable while nb_valid & !nb_ready.
  - On nb_valid & nb_ready: index increments. If the index was K-1, the index wraps to 0 and the state goes to DONE.
- DONE (1 cycle): done=1; next state IDLE.
- Fewer than K candidates (including n_points=0): the unfilled entries are still read out and show dist = all-ones, label 0. The consumer treats all-ones distance as empty.
- Latency with continuous cand_valid and nb_ready, start accepted at edge 0:
  - CLEAR in cycle 1; INSERT in cycles 2..n+1; SETTLE in cycle n+2; READ in cycles n+3..n+K+2.
  - done is high in cycle n+K+3.
- Counters are N_W bits. n_points = 2^N_W - 1 is legal, with no wrap before termination.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> busy, done, cand_ready, list_valid, list_clear, nb_valid all 0. Release rst_n -> IDLE, outputs still 0.
- K=10, n_points=3, candidates (50,L1),(10,L2),(30,L3) back-to-back, behavioural list model, nb_ready=1:
  - list_clear seen once, then exactly 3 list_valid pulses, each one cycle after its handshake.
  - Readout is (10,L2),(30,L3),(50,L1), then 7 entries of (all-ones,0); nb_idx runs 0..9.
  - done is high in cycle 16.
- n_points=12, K=10, continuous valid/ready -> cand_ready high for exactly 12 cycles; done high in cycle 25; the 10 smallest of the 12 distances come out ascending.
- n_points=0 -> no cand_ready; CLEAR, SETTLE, then 10 all-ones entries; done in cycle 13.
- Backpressure: nb_ready low for 3 cycles at idx 4, and cand_valid gaps of 2 cycles -> nb outputs held constant, no index skip, no extra list_valid, correct final order.
- Faults:
  - start pulsed during INSERT -> ignored, cnt_max unchanged.
  - rst_n pulsed low in cycle 5 of INSERT -> immediate IDLE and all outputs 0.
  - A new start afterwards -> a full, correct run.

Source files
------------

// File: rtl/knn_list_ctrl_if.sv
// knn_list_ctrl_if: bundle of control, candidate, list and neighbour signals
//   slave  : controller side (knn_list_ctrl)
//   master : environment side (distance unit, list chain, vote logic)
interface knn_list_ctrl_if #(
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 8,
   parameter int K       = 10,
   parameter int N_W     = 16,
   parameter int SEL_W   = $clog2(K)
);
   logic               start;
   logic [N_W-1:0]     n_points;
   logic               busy;
   logic               done;
   logic               cand_valid;
   logic               cand_ready;
   logic [DATA_W-1:0]  cand_dist;
   logic [LABEL_W-1:0] cand_label;
   logic               list_clear;
   logic               list_start;
   logic               list_valid;
   logic [DATA_W-1:0]  list_dist;
   logic [LABEL_W-1:0] list_label;
   logic [SEL_W-1:0]   list_sel;
   logic [DATA_W-1:0]  list_rd_dist;
   logic [LABEL_W-1:0] list_rd_label;
   logic               nb_valid;
   logic               nb_ready;
   logic [DATA_W-1:0]  nb_dist;
   logic [LABEL_W-1:0] nb_label;
   logic [SEL_W-1:0]   nb_idx;
   modport slave (
      input  start, n_points, cand_valid, cand_dist, cand_label,
             list_rd_dist, list_rd_label, nb_ready,
      output busy, done, cand_ready, list_clear, list_start, list_valid,
             list_dist, list_label, list_sel, nb_valid, nb_dist, nb_label, nb_idx
   );
   modport master (
      output start, n_points, cand_valid, cand_dist, cand_label,
             list_rd_dist, list_rd_label, nb_ready,
      input  busy, done, cand_ready, list_clear, list_start, list_valid,
             list_dist, list_label, list_sel, nb_valid, nb_dist, nb_label, nb_idx
   );
endinterface

// File: rtl/knn_list_ctrl.sv
// knn_list_ctrl: sequences clear, candidate insertion and sorted readout of the K-entry neighbour list
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/n_points/busy/done control, candidate stream in,
//                list drive and readout select, neighbour stream out
module knn_list_ctrl #(
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 8,
   parameter int K       = 10,
   parameter int N_W     = 16,
   parameter int SEL_W   = $clog2(K)
) (
   input logic          clk,
   input logic          rst_n,
   knn_list_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, INSERT, SETTLE, READ, DONE} state_t;
   state_t             state_q, state_d;
   logic [N_W-1:0]     cnt_max_q, cnt_q;
   logic [SEL_W-1:0]   idx_q;
   logic               busy_q, done_q, cand_ready_q, list_clear_q, list_start_q, list_valid_q, nb_valid_q;
   logic [DATA_W-1:0]  list_dist_q;
   logic [LABEL_W-1:0] list_label_q;
   logic               cand_hs, nb_hs, last_cand, last_nb;
   assign cand_hs   = cand_ready_q & bus.cand_valid;
   assign nb_hs     = nb_valid_q & bus.nb_ready;
   assign last_cand = (cnt_q + N_W'(1)) == cnt_max_q;
   assign last_nb   = idx_q == SEL_W'(K - 1);
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.start ? CLEAR : IDLE;
         CLEAR:   state_d = (cnt_max_q != '0) ? INSERT : SETTLE;
         INSERT:  state_d = (cand_hs && last_cand) ? SETTLE : INSERT;
         SETTLE:  state_d = READ;
         READ:    state_d = (nb_hs && last_nb) ? DONE : READ;
         default: state_d = IDLE;
      endcase
   end
   // Status/strobe outputs are registered decodes of the next state so they
   // line up exactly with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_max_q    <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cand_ready_q <= 1'b0;
         list_clear_q <= 1'b0;
         list_start_q <= 1'b0;
         list_valid_q <= 1'b0;
         nb_valid_q   <= 1'b0;
         list_dist_q  <= '0;
         list_label_q <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= state_d != IDLE;
         done_q       <= state_d == DONE;
         cand_ready_q <= state_d == INSERT;
         list_clear_q <= state_d == CLEAR;
         list_start_q <= (state_d == INSERT) || (state_d == SETTLE);
         nb_valid_q   <= state_d == READ;
         list_valid_q <= cand_hs;
         if (state_q == IDLE && bus.start) cnt_max_q <= bus.n_points;
         if (state_q == CLEAR) cnt_q <= '0;
         else if (cand_hs) cnt_q <= cnt_q + N_W'(1);
         if (cand_hs) begin
            list_dist_q  <= bus.cand_dist;
            list_label_q <= bus.cand_label;
         end
         // idx is zero on entry to SETTLE, so it doubles as list_sel there
         if (nb_hs) idx_q <= last_nb ? '0 : idx_q + SEL_W'(1);
      end
   end
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.cand_ready = cand_ready_q;
   assign bus.list_clear = list_clear_q;
   assign bus.list_start = list_start_q;
   assign bus.list_valid = list_valid_q;
   assign bus.list_dist  = list_dist_q;
   assign bus.list_label = list_label_q;
   assign bus.list_sel   = idx_q;
   assign bus.nb_valid   = nb_valid_q;
   assign bus.nb_idx     = idx_q;
   assign bus.nb_dist    = nb_valid_q ? bus.list_rd_dist : '0;
   assign bus.nb_label   = nb_valid_q ? bus.list_rd_label : '0;
endmodule

// File: tb/tb_knn_list_ctrl.sv
// tb_knn_list_ctrl: table-driven and randomized checks of knn_list_ctrl against a sorted-list reference
module tb_knn_list_ctrl;
   localparam int DATA_W  = 32;
   localparam int LABEL_W = 8;
   localparam int K       = 10;
   localparam int N_W     = 16;
   localparam int SEL_W   = $clog2(K);
   localparam logic [DATA_W-1:0] EMPTY = '1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   knn_list_ctrl_if #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K), .N_W(N_W), .SEL_W(SEL_W)) bus ();
   knn_list_ctrl #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K), .N_W(N_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct packed {
      logic [DATA_W-1:0]  d;
      logic [LABEL_W-1:0] l;
   } ent_t;
   typedef ent_t [K-1:0] lst_t;

   // Behavioural list chain: sorted ascending, new entry placed after equals.
   lst_t lst;
   function automatic lst_t ins(input lst_t a, input ent_t e);
      lst_t r = a;
      bit placed = 0;
      for (int i = 0; i < K; i++)
         if (!placed && e.d < a[i].d) begin
            placed = 1;
            r[i] = e;
            for (int j = i + 1; j < K; j++) r[j] = a[j-1];
         end
      return r;
   endfunction
   function automatic lst_t empty_lst();
      lst_t r;
      for (int i = 0; i < K; i++) begin
         r[i].d = EMPTY;
         r[i].l = '0;
      end
      return r;
   endfunction
   always @(posedge clk)
      if (bus.list_clear) lst <= empty_lst();
      else if (bus.list_valid) lst <= ins(lst, {bus.list_dist, bus.list_label});
   assign bus.list_rd_dist  = (int'(bus.list_sel) < K) ? lst[bus.list_sel].d : '0;
   assign bus.list_rd_label = (int'(bus.list_sel) < K) ? lst[bus.list_sel].l : '0;

   int checks = 0;
   int errors = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {48'd0, bus.busy, bus.done, bus.cand_ready, bus.list_clear, bus.list_start,
              bus.list_valid, bus.nb_valid, 1'b0, bus.nb_idx, bus.list_sel};
   endfunction

   typedef struct {
      int n;
      bit fixed;
      bit gaps;
      bit bp;
      bit rnd;
      bit start_ins;
      int exp_done;
      int exp_ready;
   } vec_t;
   vec_t tbl[7];

   task automatic run(input vec_t v, input string nm);
      logic [DATA_W-1:0] cd[$];
      logic [LABEL_W-1:0] cl[$];
      ent_t exp_q[$];
      ent_t got[$];
      bit used[$];
      ent_t e, held_e;
      logic [SEL_W-1:0] held_i;
      int sent = 0, c = 0, gap = 0, stall = 0, stalls = 0, last_hs = 1, done_cyc = -1;
      int rdy = 0, clr = 0, lv = 0, lv_bad = 0, hold_bad = 0, idx_bad = 0;
      bit hs_prev = 0, hs_now, held = 0;
      for (int i = 0; i < v.n; i++) begin
         if (v.fixed) begin
            cd.push_back((i == 0) ? 32'd50 : (i == 1) ? 32'd10 : 32'd30);
            cl.push_back(LABEL_W'(i + 1));
         end else begin
            cd.push_back(($urandom_range(0, 4095) << 6) | i);
            cl.push_back(LABEL_W'($urandom_range(1, 255)));
         end
         used.push_back(0);
      end
      for (int k = 0; k < K; k++) begin
         int best = -1;
         for (int i = 0; i < v.n; i++)
            if (!used[i] && (best < 0 || cd[i] < cd[best])) best = i;
         if (best >= 0) begin
            used[best] = 1;
            e.d = cd[best];
            e.l = cl[best];
         end else begin
            e.d = EMPTY;
            e.l = '0;
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.n_points = N_W'(v.n);
      @(posedge clk);
      while (c < 400) begin
         @(negedge clk);
         c++;
         bus.start = 1'b0;
         if (v.start_ins && c == 3) begin
            bus.start = 1'b1;
            bus.n_points = N_W'(7);
         end
         rdy += int'(bus.cand_ready);
         clr += int'(bus.list_clear);
         lv  += int'(bus.list_valid);
         if (bus.list_valid !== hs_prev) lv_bad++;
         if (held && (!bus.nb_valid || bus.nb_dist !== held_e.d || bus.nb_label !== held_e.l || bus.nb_idx !== held_i))
            hold_bad++;
         if (bus.done) begin
            done_cyc = c;
            break;
         end
         if (gap > 0) gap--;
         bus.cand_valid = (sent < v.n) && gap == 0 && (!v.rnd || $urandom_range(0, 3) != 0);
         if (sent < v.n) begin
            bus.cand_dist  = cd[sent];
            bus.cand_label = cl[sent];
         end
         hs_now = bus.cand_valid && bus.cand_ready;
         if (v.bp && bus.nb_valid && bus.nb_idx == SEL_W'(4) && stall < 3) begin
            bus.nb_ready = 1'b0;
            stall++;
         end else bus.nb_ready = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (bus.nb_valid && !bus.nb_ready) stalls++;
         if (bus.nb_valid && bus.nb_ready) begin
            if (int'(bus.nb_idx) != got.size()) idx_bad++;
            e.d = bus.nb_dist;
            e.l = bus.nb_label;
            got.push_back(e);
         end
         held = bus.nb_valid && !bus.nb_ready;
         held_e.d = bus.nb_dist;
         held_e.l = bus.nb_label;
         held_i = bus.nb_idx;
         if (hs_now) begin
            sent++;
            last_hs = c;
            gap = v.gaps ? 3 : 0;
         end
         hs_prev = hs_now;
      end
      bus.cand_valid = 1'b0;
      bus.nb_ready = 1'b0;
      chk({nm, " timeout"}, 64'(done_cyc >= 0), 64'd1);
      chk({nm, " done_cycle"}, 64'(done_cyc), 64'(last_hs + K + 2 + stalls));
      if (v.exp_done >= 0) chk({nm, " done_abs"}, 64'(done_cyc), 64'(v.exp_done));
      if (v.exp_ready >= 0) chk({nm, " ready_cycles"}, 64'(rdy), 64'(v.exp_ready));
      chk({nm, " clear_count"}, 64'(clr), 64'd1);
      chk({nm, " valid_count"}, 64'(lv), 64'(v.n));
      chk({nm, " valid_timing"}, 64'(lv_bad), 64'd0);
      chk({nm, " hold"}, 64'(hold_bad), 64'd0);
      chk({nm, " idx_seq"}, 64'(idx_bad), 64'd0);
      chk({nm, " read_count"}, 64'(got.size()), 64'(K));
      for (int i = 0; i < K && i < got.size(); i++) begin
         chk($sformatf("%s dist[%0d]", nm, i), 64'(got[i].d), 64'(exp_q[i].d));
         chk($sformatf("%s label[%0d]", nm, i), 64'(got[i].l), 64'(exp_q[i].l));
      end
      @(negedge clk);
      chk({nm, " idle_after"}, outs(), 64'd0);
   endtask

   task automatic abort_seq();
      @(negedge clk);
      bus.start = 1'b1;
      bus.n_points = N_W'(12);
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.cand_valid = 1'b1;
         bus.cand_dist = $urandom;
         bus.cand_label = LABEL_W'($urandom);
      end
      chk("abort pre_ready", 64'(bus.cand_ready), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort outs", outs(), 64'd0);
      chk("abort list_dist", 64'(bus.list_dist), 64'd0);
      chk("abort nb_dist", 64'(bus.nb_dist), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.cand_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort idle", outs(), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3, 1, 0, 0, 0, 0, 16, 3};
      tbl[1] = '{12, 0, 0, 0, 0, 0, 25, 12};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 13, 0};
      tbl[3] = '{3, 1, 1, 1, 0, 0, -1, -1};
      tbl[4] = '{3, 1, 0, 0, 0, 1, 16, 3};
      tbl[5] = '{5, 0, 0, 0, 0, 0, 18, 5};
      tbl[6] = '{20, 0, 0, 0, 1, 0, -1, -1};
      bus.start = 1'b0;
      bus.n_points = '0;
      bus.cand_valid = 1'b0;
      bus.cand_dist = '0;
      bus.cand_label = '0;
      bus.nb_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.start = 1'($urandom);
         bus.n_points = N_W'($urandom);
         bus.cand_valid = 1'($urandom);
         bus.cand_dist = $urandom;
         bus.cand_label = LABEL_W'($urandom);
         bus.nb_ready = 1'($urandom);
         #1;
         chk($sformatf("reset outs[%0d]", c), outs(), 64'd0);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.cand_valid = 1'b0;
      bus.nb_ready = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset released", outs(), 64'd0);
      for (int i = 0; i < 7; i++) begin
         if (i == 5) abort_seq();
         run(tbl[i], $sformatf("vec%0d", i));
      end
      for (int r = 0; r < 3; r++) begin
         vec_t v;
         v.n = $urandom_range(0, 16);
         v.fixed = 0;
         v.gaps = 1'($urandom);
         v.bp = 1'($urandom);
         v.rnd = 1'b1;
         v.start_ins = 0;
         v.exp_done = -1;
         v.exp_ready = -1;
         run(v, $sformatf("rnd%0d", r));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
